// File: rtl/lane_shift_right_seq.sv
// Sequential lane right shifter: moves a word down by one lane per clock.
// Vacated upper lanes take a captured fill value. Valid/ready handshakes on both sides.
module lane_shift_right_seq #(
    parameter int LANE_W    = 12,
    parameter int LANES     = 8,
    parameter int MAX_SHIFT = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANE_W*LANES-1:0]   in_data,
    input  logic [2:0]                in_shift,
    input  logic [LANE_W-1:0]         in_fill,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANE_W*LANES-1:0]   out_data,
    output logic                      out_err
);

    localparam int W = LANE_W * LANES;
    localparam logic [2:0] MAX_S = 3'(MAX_SHIFT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]        state;
    logic [W-1:0]      data_q;
    logic [LANE_W-1:0] fill_q;
    logic [2:0]        count_q;
    logic              err_q;

    logic accept;
    logic shift_bad;

    // A finishing word can hand off to the next one in the same cycle, so DONE
    // only offers ready when downstream is taking the current result.
    assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign shift_bad = in_shift > MAX_S;

    assign out_valid = (state == DONE);
    assign out_data  = data_q;
    assign out_err   = err_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            data_q  <= '0;
            fill_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            data_q  <= in_data;
            fill_q  <= in_fill;
            count_q <= in_shift;
            err_q   <= shift_bad;
            state   <= ((in_shift == 3'd0) || shift_bad) ? DONE : SHIFT;
        end else begin
            case (state)
                SHIFT: begin
                    data_q  <= {fill_q, data_q[W-1:LANE_W]};
                    count_q <= count_q - 3'd1;
                    if (count_q == 3'd1) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lane_shift_right_seq.sv
// Bench for lane_shift_right_seq: directed vector table, multi-cycle corner
// sequences, and a randomised stream checked through a scoreboard queue.
module tb_lane_shift_right_seq;

    localparam int LW = 12;
    localparam int LN = 8;
    localparam int W  = LW * LN;
    localparam int N_RAND  = 10000;
    localparam int CYC_MAX = 95000;

    typedef struct {
        logic [W-1:0]  data;
        logic [2:0]    shift;
        logic [LW-1:0] fill;
        logic [W-1:0]  exp_data;
        logic          exp_err;
        int            exp_lat;
    } vec_t;

    typedef struct {
        logic [W-1:0] data;
        logic         err;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [2:0]    in_shift = '0;
    logic [LW-1:0] in_fill = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_err;

    int checks = 0;
    int failures = 0;
    int pushed = 0;
    int popped = 0;
    res_t sb_q[$];

    always #5 clk = ~clk;

    lane_shift_right_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .in_fill   (in_fill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] d, input logic [2:0] s, input logic [LW-1:0] f);
        res_t r;
        r.err  = (s > 3'd5);
        r.data = d;
        if (!r.err) begin
            for (int i = 0; i < LN; i++) begin
                if (i + int'(s) < LN) r.data[i*LW +: LW] = d[(i + int'(s))*LW +: LW];
                else                  r.data[i*LW +: LW] = f;
            end
        end
        return r;
    endfunction

    // Scoreboard monitor: pushes on accept, pops on output handshake, and
    // checks that a stalled result stays valid and stable.
    logic         hold_valid = 1'b0;
    logic [W-1:0] hold_data;
    logic         hold_err;

    always @(negedge clk) begin
        res_t e;
        if (!rst_n) begin
            hold_valid = 1'b0;
        end else begin
            if (hold_valid) begin
                check("hold_valid", W'(out_valid), W'(1'b1));
                check("hold_data", out_data, hold_data);
                check("hold_err", W'(out_err), W'(hold_err));
            end
            if (out_valid && out_ready) begin
                check("sb_nonempty", W'(sb_q.size() != 0), W'(1'b1));
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    popped++;
                    check("sb_data", out_data, e.data);
                    check("sb_err", W'(out_err), W'(e.err));
                end
                hold_valid = 1'b0;
            end else if (out_valid) begin
                hold_valid = 1'b1;
                hold_data  = out_data;
                hold_err   = out_err;
            end else begin
                hold_valid = 1'b0;
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(model(in_data, in_shift, in_fill));
                pushed++;
            end
        end
    end

    // Drive one request from IDLE with out_ready high; measure cycles from the
    // edge after which it is presented to the first sample with out_valid high.
    task automatic run_vec(input vec_t v, input string name);
        int lat = 0;
        bit got = 0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = v.data;
        in_shift  = v.shift;
        in_fill   = v.fill;
        while (lat < 20 && !got) begin
            @(posedge clk); #1;
            lat++;
            in_valid = 1'b0;
            in_data  = ~v.data;
            in_shift = ~v.shift;
            in_fill  = ~v.fill;
            @(negedge clk);
            if (out_valid) got = 1;
        end
        check({name, "_valid"}, W'(got), W'(1'b1));
        check({name, "_lat"}, W'(lat), W'(v.exp_lat));
        check({name, "_data"}, out_data, v.exp_data);
        check({name, "_err"}, W'(out_err), W'(v.exp_err));
        @(posedge clk); #1;
    endtask

    localparam logic [W-1:0] WORD_A = 96'h008_007_006_005_004_003_002_001;
    localparam logic [W-1:0] WORD_B = 96'h0BB_0AA_099_088_077_066_055_044;
    localparam logic [W-1:0] WORD_C = 96'h017_016_015_014_013_012_011_010;

    vec_t vecs[7];

    initial begin
        int  n_acc;
        int  cyc;
        bit  acc;
        bit  got;

        vecs[0] = '{WORD_A, 3'd3, 12'hFFF, 96'hFFF_FFF_FFF_008_007_006_005_004, 1'b0, 4};
        vecs[1] = '{WORD_A, 3'd0, 12'hFFF, WORD_A, 1'b0, 1};
        vecs[2] = '{WORD_A, 3'd5, 12'hA5A, 96'hA5A_A5A_A5A_A5A_A5A_008_007_006, 1'b0, 6};
        vecs[3] = '{WORD_A, 3'd6, 12'hFFF, WORD_A, 1'b1, 1};
        vecs[4] = '{WORD_A, 3'd7, 12'h000, WORD_A, 1'b1, 1};
        vecs[5] = '{WORD_A, 3'd1, 12'h123, 96'h123_008_007_006_005_004_003_002, 1'b0, 2};
        vecs[6] = '{WORD_B, 3'd2, 12'h000, 96'h000_000_0BB_0AA_099_088_077_066, 1'b0, 3};

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", W'(out_valid), W'(1'b0));
        check("rst_out_data", out_data, '0);
        check("rst_out_err", W'(out_err), W'(1'b0));
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", W'(in_ready), W'(1'b1));

        // Directed table
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-pressure in DONE, then handshake and new accept in the same cycle
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = WORD_A;
        in_shift  = 3'd2;
        in_fill   = 12'h111;
        @(posedge clk); #1;
        in_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (out_valid) got = 1;
            else begin @(posedge clk); #1; end
        end
        check("bp_valid", W'(got), W'(1'b1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_stall_valid", W'(out_valid), W'(1'b1));
            check("bp_stall_data", out_data, 96'h111_111_008_007_006_005_004_003);
            check("bp_stall_in_ready", W'(in_ready), W'(1'b0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = WORD_C;
        in_shift  = 3'd1;
        in_fill   = 12'h000;
        @(negedge clk);
        check("bp_same_cycle_ready", W'(in_ready), W'(1'b1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_second_shifting", W'(out_valid), W'(1'b0));
        @(negedge clk);
        check("bp_second_valid", W'(out_valid), W'(1'b1));
        check("bp_second_data", out_data, 96'h000_017_016_015_014_013_012_011);
        check("bp_second_err", W'(out_err), W'(1'b0));
        @(posedge clk); #1;

        // Asynchronous reset two cycles into a shift=5 word
        in_valid = 1'b1;
        in_data  = WORD_A;
        in_shift = 3'd5;
        in_fill  = 12'hA5A;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb_q.delete();
        pushed = 0;
        popped = 0;
        #1;
        check("abort_out_valid", W'(out_valid), W'(1'b0));
        check("abort_out_data", out_data, '0);
        check("abort_out_err", W'(out_err), W'(1'b0));
        @(negedge clk);
        check("abort_in_ready", W'(in_ready), W'(1'b1));
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[6], "post_reset");

        // Random stream with stalls on both sides
        n_acc = 0;
        cyc   = 0;
        in_valid = 1'b0;
        while (n_acc < N_RAND && cyc < CYC_MAX) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                n_acc++;
                in_valid = 1'b0;
                in_data  = {$urandom, $urandom, $urandom};
            end
            if (!in_valid && n_acc < N_RAND && $urandom_range(0, 7) != 0) begin
                in_valid = 1'b1;
                in_data  = {$urandom, $urandom, $urandom};
                in_shift = 3'($urandom_range(0, 7));
                in_fill  = 12'($urandom);
            end
            out_ready = ($urandom_range(0, 7) != 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (sb_q.size() != 0 || out_valid); i++) begin
            @(negedge clk);
        end
        check("rand_all_accepted", W'(n_acc), W'(N_RAND));
        check("rand_sb_drained", W'(sb_q.size()), '0);
        check("rand_push_pop", W'(popped), W'(pushed));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
